// File: rtl/exu_gpr_datapath.sv
// RV32I execute/register-file slice: reset conditioner, 32x32 GPR file and combinational ALU.
// Define EXU_MUL_EN to enable op 10 (MUL, low half); otherwise op 10 returns 0 and no multiplier exists.
module exu_gpr_datapath #(
  parameter int CPU_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [CPU_WIDTH-1:0]  pc,
  input  logic [CPU_WIDTH-1:0]  imm,
  input  logic [ADDR_WIDTH-1:0] addr_rs1,
  input  logic [ADDR_WIDTH-1:0] addr_rs2,
  input  logic [ADDR_WIDTH-1:0] addr_rd,
  input  logic                  wr_en_rd,
  input  logic [3:0]            exu_opt_code,
  input  logic [2:0]            exu_sel_code,
  output logic                  rst_sync,
  output logic [CPU_WIDTH-1:0]  data_rs1,
  output logic [CPU_WIDTH-1:0]  data_rs2,
  output logic [CPU_WIDTH-1:0]  exu_res
);

  localparam int NREG = 2 ** ADDR_WIDTH;
  localparam int SHW  = $clog2(CPU_WIDTH);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9,
    OP_MUL  = 4'd10
  } exu_op_e;

  typedef enum logic [2:0] {
    SEL_RS1_RS2 = 3'd0,
    SEL_RS1_IMM = 3'd1,
    SEL_PC_IMM  = 3'd2,
    SEL_PC_4    = 3'd3,
    SEL_0_IMM   = 3'd4
  } exu_sel_e;

  // Reset conditioner: asynchronous assertion, release on the first clk edge after rstn drops.
  logic rst_sync_d, rst_sync_q;

  always_comb begin
    rst_sync_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) rst_sync_q <= 1'b1;
    else      rst_sync_q <= rst_sync_d;
  end

  assign rst_sync = rst_sync_q;

  // GPR file; cleared asynchronously by the conditioned reset, which also blocks writes.
  logic [CPU_WIDTH-1:0] gpr_q [NREG];
  logic [CPU_WIDTH-1:0] gpr_d [NREG];

  always_comb begin
    gpr_d = gpr_q;
    if (wr_en_rd && (addr_rd != '0)) gpr_d[addr_rd] = exu_res;
  end

  always_ff @(posedge clk or posedge rst_sync_q) begin
    if (rst_sync_q) begin
      for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
    end else begin
      gpr_q <= gpr_d;
    end
  end

  // No write bypass: the read path sees only gpr_q, so exu_res never loops back combinationally.
  assign data_rs1 = (addr_rs1 == '0) ? '0 : gpr_q[addr_rs1];
  assign data_rs2 = (addr_rs2 == '0) ? '0 : gpr_q[addr_rs2];

  // Operand select.
  logic [CPU_WIDTH-1:0] op_a, op_b;

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (exu_sel_e'(exu_sel_code))
      SEL_RS1_RS2: begin op_a = data_rs1; op_b = data_rs2; end
      SEL_RS1_IMM: begin op_a = data_rs1; op_b = imm;      end
      SEL_PC_IMM:  begin op_a = pc;       op_b = imm;      end
      SEL_PC_4:    begin op_a = pc;       op_b = CPU_WIDTH'(4); end
      SEL_0_IMM:   begin op_a = '0;       op_b = imm;      end
      default:     begin op_a = '0;       op_b = '0;       end
    endcase
  end

  logic signed [CPU_WIDTH-1:0] op_a_s, op_b_s;
  logic        [SHW-1:0]       shamt;

  assign op_a_s = op_a;
  assign op_b_s = op_b;
  assign shamt  = op_b[SHW-1:0];

  // ALU; everything wraps modulo 2**CPU_WIDTH.
  always_comb begin
    exu_res = '0;
    case (exu_op_e'(exu_opt_code))
      OP_ADD:  exu_res = op_a + op_b;
      OP_SUB:  exu_res = op_a - op_b;
      OP_SLL:  exu_res = op_a << shamt;
      OP_SLT:  exu_res = {{(CPU_WIDTH-1){1'b0}}, (op_a_s < op_b_s)};
      OP_SLTU: exu_res = {{(CPU_WIDTH-1){1'b0}}, (op_a < op_b)};
      OP_XOR:  exu_res = op_a ^ op_b;
      OP_SRL:  exu_res = op_a >> shamt;
      OP_SRA:  exu_res = op_a_s >>> shamt;
      OP_OR:   exu_res = op_a | op_b;
      OP_AND:  exu_res = op_a & op_b;
`ifdef EXU_MUL_EN
      OP_MUL:  exu_res = op_a * op_b;
`else
      OP_MUL:  exu_res = '0;
`endif
      default: exu_res = '0;
    endcase
  end

endmodule

// File: tb/tb_exu_gpr_datapath.sv
// Directed self-checking bench for exu_gpr_datapath (honours EXU_MUL_EN for the MUL vector).
module tb_exu_gpr_datapath;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] imm = '0;
  logic [4:0]  addr_rs1 = '0;
  logic [4:0]  addr_rs2 = '0;
  logic [4:0]  addr_rd = '0;
  logic        wr_en_rd = 1'b0;
  logic [3:0]  exu_opt_code = '0;
  logic [2:0]  exu_sel_code = '0;
  logic        rst_sync;
  logic [31:0] data_rs1, data_rs2, exu_res;

  int checks = 0;
  int errors = 0;

  exu_gpr_datapath #(.CPU_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .pc           (pc),
    .imm          (imm),
    .addr_rs1     (addr_rs1),
    .addr_rs2     (addr_rs2),
    .addr_rd      (addr_rd),
    .wr_en_rd     (wr_en_rd),
    .exu_opt_code (exu_opt_code),
    .exu_sel_code (exu_sel_code),
    .rst_sync     (rst_sync),
    .data_rs1     (data_rs1),
    .data_rs2     (data_rs2),
    .exu_res      (exu_res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write val into register rd through sel=4 (0+imm), op ADD.
  task automatic wr(input logic [4:0] rd, input logic [31:0] val);
    exu_sel_code = 3'd4;
    exu_opt_code = 4'd0;
    imm          = val;
    addr_rd      = rd;
    wr_en_rd     = 1'b1;
    @(posedge clk);
    #1;
    wr_en_rd     = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] exp;
    string       tag;
  } alu_vec_t;

  alu_vec_t alu_tab[15] = '{
    '{4'd0,  32'hFFFF_FFF4, "add"},
    '{4'd1,  32'hFFFF_FFEC, "sub"},
    '{4'd2,  32'hFFFF_FF00, "sll"},
    '{4'd3,  32'h0000_0001, "slt"},
    '{4'd4,  32'h0000_0000, "sltu"},
    '{4'd5,  32'hFFFF_FFF4, "xor"},
    '{4'd6,  32'h0FFF_FFFF, "srl"},
    '{4'd7,  32'hFFFF_FFFF, "sra"},
    '{4'd8,  32'hFFFF_FFF4, "or"},
    '{4'd9,  32'h0000_0000, "and"},
    '{4'd11, 32'h0000_0000, "rsv11"},
    '{4'd12, 32'h0000_0000, "rsv12"},
    '{4'd13, 32'h0000_0000, "rsv13"},
    '{4'd14, 32'h0000_0000, "rsv14"},
    '{4'd15, 32'h0000_0000, "rsv15"}
  };

  initial begin
    // 1. Reset
    #1 rstn = 1'b1;
    #1 chk("rst_async_assert", {31'b0, rst_sync}, 32'h1);
    @(posedge clk); @(posedge clk);
    #2 rstn = 1'b0;
    #1 chk("rst_held_until_edge", {31'b0, rst_sync}, 32'h1);
    @(posedge clk);
    #1 chk("rst_released", {31'b0, rst_sync}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      addr_rs1 = 5'(i);
      addr_rs2 = 5'(31 - i);
      #1;
      chk($sformatf("rst_rs1_x%0d", i), data_rs1, 32'h0);
      chk($sformatf("rst_rs2_x%0d", 31 - i), data_rs2, 32'h0);
    end

    // 2. Write/read and x0
    exu_sel_code = 3'd4; exu_opt_code = 4'd0; imm = 32'h1234; #1;
    chk("imm_path_res", exu_res, 32'h1234);
    wr(5'd5, 32'h1234);
    addr_rs1 = 5'd5; #1;
    chk("wr_x5", data_rs1, 32'h1234);
    wr(5'd0, 32'h5555);
    addr_rs1 = 5'd0; #1;
    chk("x0_stays_0", data_rs1, 32'h0);

    // 3. ALU with x1=FFFF_FFF0, x2=4
    wr(5'd1, 32'hFFFF_FFF0);
    wr(5'd2, 32'h0000_0004);
    addr_rs1 = 5'd1; addr_rs2 = 5'd2; exu_sel_code = 3'd0; #1;
    chk("rd_x1", data_rs1, 32'hFFFF_FFF0);
    chk("rd_x2", data_rs2, 32'h0000_0004);
    foreach (alu_tab[k]) begin
      exu_opt_code = alu_tab[k].op;
      #1 chk(alu_tab[k].tag, exu_res, alu_tab[k].exp);
    end
    exu_sel_code = 3'd1; exu_opt_code = 4'd0; imm = 32'h20; #1;
    chk("sel1_rs1_imm", exu_res, 32'h0000_0010);
    exu_opt_code = 4'd2; imm = 32'h24; #1;
    chk("sll_uses_b4_0", exu_res, 32'hFFFF_FF00);

    // No bypass: same-cycle read of rd returns the old value
    addr_rs1 = 5'd1; exu_sel_code = 3'd4; exu_opt_code = 4'd0; imm = 32'hAA;
    addr_rd = 5'd1; wr_en_rd = 1'b1; #1;
    chk("no_bypass_old", data_rs1, 32'hFFFF_FFF0);
    @(posedge clk); #1 wr_en_rd = 1'b0;
    chk("wb_visible_next", data_rs1, 32'h0000_00AA);

    // 4. Operand select
    pc = 32'h8000_0000; imm = 32'h10; exu_opt_code = 4'd0;
    exu_sel_code = 3'd2; #1 chk("sel2_pc_imm", exu_res, 32'h8000_0010);
    exu_sel_code = 3'd3; #1 chk("sel3_pc_4", exu_res, 32'h8000_0004);
    exu_opt_code = 4'd15; #1 chk("sel3_op15", exu_res, 32'h0);
    exu_opt_code = 4'd1; exu_sel_code = 3'd4; #1 chk("sel4_sub", exu_res, 32'hFFFF_FFF0);
    exu_opt_code = 4'd8; exu_sel_code = 3'd5; #1 chk("sel5_zero", exu_res, 32'h0);
    exu_sel_code = 3'd7; #1 chk("sel7_zero", exu_res, 32'h0);

    // 5. Async reset mid-run
    addr_rs1 = 5'd5; addr_rs2 = 5'd1; #1;
    chk("pre_rst_x5", data_rs1, 32'h1234);
    @(posedge clk); #3 rstn = 1'b1;
    #1;
    chk("mid_rst_sync", {31'b0, rst_sync}, 32'h1);
    chk("mid_rst_x5", data_rs1, 32'h0);
    chk("mid_rst_x1", data_rs2, 32'h0);
    exu_sel_code = 3'd4; exu_opt_code = 4'd0; imm = 32'h77; addr_rd = 5'd7; wr_en_rd = 1'b1;
    #1 rstn = 1'b0;
    addr_rs1 = 5'd7;
    @(posedge clk); #1;
    chk("rst_release_edge", {31'b0, rst_sync}, 32'h0);
    chk("wr_ignored_in_rst", data_rs1, 32'h0);
    @(posedge clk); #1 wr_en_rd = 1'b0;
    chk("wr_after_rst", data_rs1, 32'h77);

    // 6. MUL
    wr(5'd1, 32'h7);
    wr(5'd2, 32'hFFFF_FFFD);
    addr_rs1 = 5'd1; addr_rs2 = 5'd2; exu_sel_code = 3'd0; exu_opt_code = 4'd10; #1;
`ifdef EXU_MUL_EN
    chk("mul", exu_res, 32'hFFFF_FFEB);
`else
    chk("mul_disabled", exu_res, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
